// File: rtl/spi_display_rx.sv
// Panel-side SPI receiver: decodes SET_COLUMN/SET_PAGE/WRITE_RAM into addressed RGB565 pixel writes.
// Latency: 4 i_clk cycles from the raw SCLK rise of bit 0 (the 8th bit) to o_cmd_valid/o_pix_we.
// Backpressure: none; the frame-buffer port must accept every strobe. Optional stats: SPI_DISPLAY_RX_STATS_EN.
`timescale 1ns/1ps
module spi_display_rx #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sclk,
   input  logic        i_mosi,
   input  logic        i_dc,
   input  logic        i_cs,
   output logic        o_cmd_valid,
   output logic [7:0]  o_cmd,
   output logic        o_pix_we,
   output logic [15:0] o_pix_x,
   output logic [15:0] o_pix_y,
   output logic [15:0] o_pix_data,
   output logic [31:0] o_pix_count,
   output logic [15:0] o_err_count
);

   localparam logic [15:0] LP_W = 16'(WIDTH);
   localparam logic [15:0] LP_H = 16'(HEIGHT);

   typedef enum logic [2:0] {M_IDLE, M_COL, M_PAGE, M_RAM, M_IGNORE} mode_t;

   // serial front end
   logic [1:0]  r_sclk_sync, r_mosi_sync, r_dc_sync, r_cs_sync;
   logic        r_sclk_prev;
   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_shift;
   logic        r_dc_lat;
   logic        r_byte_vld;
   logic [7:0]  r_byte;
   logic        r_byte_dc;
   logic        r_abort;
   logic        w_sclk_rise;

   // decoder state
   mode_t       r_mode, w_mode_next;
   logic [2:0]  r_idx;
   logic [15:0] r_start;
   logic [7:0]  r_end_hi;
   logic [15:0] r_xs, r_xe, r_ys, r_ye;
   logic [15:0] r_x, r_y;
   logic        r_phase;
   logic [7:0]  r_pix_hi;

   logic        w_is_cmd, w_is_data, w_pix_done, w_pix_wr;
   logic [15:0] w_end, w_end_clamped, w_x_adv, w_y_adv;

   assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev & ~r_cs_sync[1];

   // Two-flop synchronizers plus previous-SCLK register for rise detection
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sclk_sync <= 2'b00;
         r_mosi_sync <= 2'b00;
         r_dc_sync   <= 2'b00;
         r_cs_sync   <= 2'b11;
         r_sclk_prev <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[0], i_sclk};
         r_mosi_sync <= {r_mosi_sync[0], i_mosi};
         r_dc_sync   <= {r_dc_sync[0], i_dc};
         r_cs_sync   <= {r_cs_sync[0], i_cs};
         r_sclk_prev <= r_sclk_sync[1];
      end
   end

   // Byte assembly: shift MSB first, flag a byte on the 8th rise, flag an abort when CS ends a partial byte
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bit_cnt  <= 3'd0;
         r_shift    <= 7'd0;
         r_dc_lat   <= 1'b0;
         r_byte_vld <= 1'b0;
         r_byte     <= 8'd0;
         r_byte_dc  <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_byte_vld <= 1'b0;
         r_abort    <= 1'b0;
         if (r_cs_sync[1]) begin
            if (r_bit_cnt != 3'd0) r_abort <= 1'b1;
            r_bit_cnt <= 3'd0;
         end else if (w_sclk_rise) begin
            // D/C belongs to the byte whose MSB is being sampled
            if (r_bit_cnt == 3'd0) r_dc_lat <= r_dc_sync[1];
            r_shift   <= {r_shift[5:0], r_mosi_sync[1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_byte_vld <= 1'b1;
               r_byte     <= {r_shift, r_mosi_sync[1]};
               r_byte_dc  <= r_dc_lat;
            end
         end
      end
   end

   assign w_is_cmd      = r_byte_vld & ~r_byte_dc;
   assign w_is_data     = r_byte_vld &  r_byte_dc;
   assign w_end         = {r_end_hi, r_byte};
   assign w_end_clamped = (w_end < r_start) ? r_start : w_end;
   assign w_pix_done    = w_is_data && (r_mode == M_RAM) && r_phase;
   assign w_pix_wr      = w_pix_done && (r_x < LP_W) && (r_y < LP_H);
   assign w_x_adv       = (r_x == r_xe) ? r_xs : r_x + 16'd1;
   assign w_y_adv       = (r_x != r_xe) ? r_y : ((r_y == r_ye) ? r_ys : r_y + 16'd1);

   // Mode register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_mode <= M_IDLE;
      else       r_mode <= w_mode_next;
   end

   // Next mode: only command bytes change the mode
   always_comb begin
      w_mode_next = r_mode;
      if (w_is_cmd) begin
         case (r_byte)
            8'h2A:   w_mode_next = M_COL;
            8'h2B:   w_mode_next = M_PAGE;
            8'h2C:   w_mode_next = M_RAM;
            default: w_mode_next = M_IGNORE;
         endcase
      end
   end

   // Command/parameter/pixel datapath and registered strobes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_cmd_valid <= 1'b0;
         o_cmd       <= 8'd0;
         o_pix_we    <= 1'b0;
         o_pix_x     <= 16'd0;
         o_pix_y     <= 16'd0;
         o_pix_data  <= 16'd0;
         r_idx       <= 3'd0;
         r_start     <= 16'd0;
         r_end_hi    <= 8'd0;
         r_xs        <= 16'd0;
         r_xe        <= LP_W - 16'd1;
         r_ys        <= 16'd0;
         r_ye        <= LP_H - 16'd1;
         r_x         <= 16'd0;
         r_y         <= 16'd0;
         r_phase     <= 1'b0;
         r_pix_hi    <= 8'd0;
      end else begin
         o_cmd_valid <= 1'b0;
         o_pix_we    <= 1'b0;
         if (w_is_cmd) begin
            o_cmd       <= r_byte;
            o_cmd_valid <= 1'b1;
            r_phase     <= 1'b0;   // a half-received pixel is dropped
            r_idx       <= 3'd0;
            if (r_byte == 8'h2C) begin
               r_x <= r_xs;
               r_y <= r_ys;
            end
         end else if (w_is_data) begin
            case (r_mode)
               M_COL, M_PAGE: begin
                  case (r_idx)
                     3'd0: r_start[15:8] <= r_byte;
                     3'd1: r_start[7:0]  <= r_byte;
                     3'd2: r_end_hi      <= r_byte;
                     3'd3: begin
                        // window changes only once all four parameters are in
                        if (r_mode == M_COL) begin
                           r_xs <= r_start;
                           r_xe <= w_end_clamped;
                        end else begin
                           r_ys <= r_start;
                           r_ye <= w_end_clamped;
                        end
                     end
                     default: ;
                  endcase
                  if (r_idx != 3'd4) r_idx <= r_idx + 3'd1;
               end
               M_RAM: begin
                  if (!r_phase) begin
                     r_pix_hi <= r_byte;
                     r_phase  <= 1'b1;
                  end else begin
                     r_phase <= 1'b0;
                     if (w_pix_wr) begin
                        o_pix_we   <= 1'b1;
                        o_pix_x    <= r_x;
                        o_pix_y    <= r_y;
                        o_pix_data <= {r_pix_hi, r_byte};
                     end
                     // cursor moves even when the pixel is off-panel
                     r_x <= w_x_adv;
                     r_y <= w_y_adv;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SPI_DISPLAY_RX_STATS_EN
   logic [31:0] r_pix_count;
   logic [15:0] r_err_count;

   // Statistics: wrapping pixel count, saturating abort count
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pix_count <= 32'd0;
         r_err_count <= 16'd0;
      end else begin
         if (w_pix_wr) r_pix_count <= r_pix_count + 32'd1;
         if (r_abort && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
      end
   end

   assign o_pix_count = r_pix_count;
   assign o_err_count = r_err_count;
`else
   logic w_unused_stats;
   assign w_unused_stats = r_abort;
   assign o_pix_count    = 32'd0;
   assign o_err_count    = 16'd0;
`endif

endmodule
